fifo_pop_scheduler: RTL and testbench
=====================================

// Module: fifo_pop_scheduler
// PURPOSE
//  Sequences pops from NUM_REQS per-requester FIFOs onto one shared output port.
//  Round-robin over non-empty FIFOs; a grant lasts up to BURST consecutive pops.
//  One registered output stage with valid/ready handshake; FIFO heads are show-ahead.
//  Sits between the FIFO bank (push side owned by requesters) and the single egress consumer.
// PARAMETERS
//  NUM_REQS  4   number of requester FIFOs (>=2, need not be a power of two)
//  WIDTH     8   packet width, equals FIFO data width
//  BURST     4   max consecutive pops per grant (>=1)
//  IDXW      $clog2(NUM_REQS)  requester index width (derived)
//  STATW     16  stats counter width (SCHED_STATS_EN only)
// PORTS
//  clk           in   1               clock, all state on rising edge
//  rst           in   1               asynchronous, active-low reset (0 = reset)
//  empty         in   NUM_REQS        FIFO empty flags, bit i = FIFO i
//  flat_head     in   NUM_REQS*WIDTH  FIFO head data, FIFO i at [(i+1)*WIDTH-1:i*WIDTH]
//  blk           in   1               1 = no pop this cycle, all state held
//  pop           out  NUM_REQS        one-hot or zero; combinational pop to FIFO i
//  out_vld       out  1               output register holds a packet
//  out_rdy       in   1               consumer accepts when out_vld & out_rdy
//  out_data      out  WIDTH           packet data
//  out_src       out  IDXW            index of source FIFO
// BEHAVIOUR
//  Reset (rst=0): out_vld=0, out_data=0, out_src=0, state=IDLE, ptr=0, cur=0, bcnt=0.
//  Reset also forces pop=0. Reset mid-burst drops any held output packet.
//  can_load = ~out_vld | out_rdy. A pop is issued only when can_load & ~blk & rst.
//  States: IDLE (no grant), GRANT (cur owns port, bcnt pops done).
//  IDLE & can_load & ~blk:
//    w = first i with ~empty[i], searching ptr, ptr+1, ... with wrap mod NUM_REQS.
//    None found -> stay IDLE, pop=0.
//    Found -> pop[w]=1, cur<=w, bcnt<=1.
//      If BURST==1: stay IDLE, ptr<=(w+1)%NUM_REQS. Else -> GRANT.
//  GRANT & can_load & ~blk:
//    ~empty[cur] -> pop[cur]=1, bcnt<=bcnt+1.
//      If bcnt+1==BURST -> IDLE, ptr<=(cur+1)%NUM_REQS.
//    empty[cur] -> no pop, -> IDLE, ptr<=(cur+1)%NUM_REQS (one bubble cycle).
//  ~can_load or blk: pop=0, state/ptr/cur/bcnt held. A burst resumes after backpressure.
//  Output register: pop cycle -> out_data<=head[sel], out_src<=sel, out_vld<=1.
//    Else if out_rdy -> out_vld<=0.
//    Latency: FIFO head to out_vld is 1 cycle. Throughput: 1 packet/cycle when out_rdy=1.
//  Full throughput under out_rdy=1: pop in the same cycle the previous packet drains.
//  Empty flags are registered by the FIFO, so the last-entry pop is followed by a
//    cycle showing empty[cur]=1. No pop ever targets an empty FIFO.
//  Index arithmetic is mod NUM_REQS, never mod 2**IDXW. bcnt width: $clog2(BURST+1).
// CONFIGURATION
//  SCHED_STATS_EN defined: extra output flat_pop_cnt [NUM_REQS*STATW-1:0].
//    Counter i increments on each pop[i] and saturates at all-ones.
//    Counters reset to 0 and are not cleared otherwise.
//  SCHED_STATS_EN undefined: no port, no counters. Scheduling behaviour is identical.
// STRUCTURE
//  sched_pkg: typedef enum {IDLE, GRANT} sched_state_t.
//    sched_pkg also holds function wrap_inc(idx, n) for mod-n increment.
//  Sub-module rr_pick #(NUM_REQS): combinational; inputs req vector and ptr.
//    Outputs: found, idx (first set bit at/after ptr, wrapping).
//  Top: state/ptr/cur/bcnt registers, pop decode, output register, optional stats.
// TESTING
//  1 All empty, out_rdy=1 for 20 cycles -> pop=0, out_vld=0 throughout.
//  2 NUM_REQS=4, BURST=4, FIFO1 holds 6 pkts, others empty, out_rdy=1.
//    -> 4 back-to-back pops of FIFO1; IDLE; FIFO1 re-picked (only requester).
//    -> remaining 2 popped; 6 outputs with out_src=1 in order.
//  3 FIFOs 0..3 each hold 8 pkts, BURST=2.
//    -> out_src sequence 0,0,1,1,2,2,3,3,0,0... with no bubbles.
//  4 FIFO2 busy, out_rdy=0 for 5 cycles mid-burst (bcnt=2).
//    -> pop=0, out_vld=1 and out_data stable while stalled.
//    -> on out_rdy=1 the burst resumes at bcnt=2; exactly 2 more pops of FIFO2.
//  5 FIFO0 has 1 pkt, FIFO3 has 3 pkts, ptr=0.
//    -> pop FIFO0, bubble on empty[0], then FIFO3 popped 3 times.
//  6 rst driven low while out_vld=1 in GRANT.
//    -> out_vld=0 and pop=0 immediately; after release, arbitration restarts at ptr=0.
//    With SCHED_STATS_EN: counters read 0 after reset.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and index helpers for the FIFO pop scheduler.
package sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   // Increment modulo n. The result is never rounded up to a power of two.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first set bit of req at or after ptr,
// wrapping modulo NUM_REQS.
module rr_pick #(
   parameter int NUM_REQS = 4,
   parameter int IDXW     = $clog2(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] req,
   input  logic [IDXW-1:0]     ptr,
   output logic                found,
   output logic [IDXW-1:0]     idx
);

   logic [IDXW-1:0] cand      [NUM_REQS];
   logic [IDXW-1:0] idx_chain [NUM_REQS+1];
   logic [NUM_REQS-1:0] hit;

   assign idx_chain[NUM_REQS] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQS; gi++) begin : g_cand
         logic [IDXW:0] sum;
         assign sum = {1'b0, ptr} + (IDXW+1)'(gi);
         assign cand[gi] = (sum >= (IDXW+1)'(NUM_REQS)) ?
                           IDXW'(sum - (IDXW+1)'(NUM_REQS)) : sum[IDXW-1:0];
         assign hit[gi] = req[cand[gi]];
         // Lower search offsets take precedence over higher ones.
         assign idx_chain[gi] = hit[gi] ? cand[gi] : idx_chain[gi+1];
      end
   endgenerate

   assign found = |req;
   assign idx   = idx_chain[0];

endmodule

// File: rtl/fifo_pop_scheduler.sv
// Round-robin burst pop scheduler from NUM_REQS show-ahead FIFOs onto one
// registered valid/ready port. Define SCHED_STATS_EN to add per-FIFO pop counters.
module fifo_pop_scheduler
   import sched_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int WIDTH    = 8,
   parameter int BURST    = 4,
   parameter int IDXW     = $clog2(NUM_REQS),
   parameter int STATW    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQS-1:0]       empty,
   input  logic [NUM_REQS*WIDTH-1:0] flat_head,
   input  logic                      blk,
   output logic [NUM_REQS-1:0]       pop,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [WIDTH-1:0]          out_data,
   output logic [IDXW-1:0]           out_src
`ifdef SCHED_STATS_EN
   ,
   output logic [NUM_REQS*STATW-1:0] flat_pop_cnt
`endif
);

   localparam int BCW = $clog2(BURST + 1);

   sched_state_t    state_reg, state_next;
   logic [IDXW-1:0] ptr_reg, ptr_next;
   logic [IDXW-1:0] cur_reg, cur_next;
   logic [BCW-1:0]  bcnt_reg, bcnt_next, bcnt_inc;
   logic [IDXW-1:0] sel;
   logic [IDXW-1:0] pick_idx;
   logic            pick_found;
   logic            pop_fire;
   logic            can_load;
   logic            go;

   logic [WIDTH-1:0] head [NUM_REQS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQS; gi++) begin : g_head
         assign head[gi] = flat_head[gi*WIDTH +: WIDTH];
      end
   endgenerate

   rr_pick #(
      .NUM_REQS (NUM_REQS),
      .IDXW     (IDXW)
   ) u_pick (
      .req   (~empty),
      .ptr   (ptr_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // The output register frees up in the same cycle it drains, so pops can
   // stream back to back while the consumer keeps out_rdy high.
   assign can_load = ~out_vld | out_rdy;
   assign go       = can_load & ~blk & rst;
   assign bcnt_inc = bcnt_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cur_next   = cur_reg;
      bcnt_next  = bcnt_reg;
      pop_fire   = 1'b0;
      sel        = cur_reg;
      if (go) begin
         case (state_reg)
            IDLE: begin
               if (pick_found) begin
                  pop_fire  = 1'b1;
                  sel       = pick_idx;
                  cur_next  = pick_idx;
                  bcnt_next = BCW'(1);
                  if (BURST == 1) begin
                     ptr_next = IDXW'(wrap_inc(32'(pick_idx), NUM_REQS));
                  end else begin
                     state_next = GRANT;
                  end
               end
            end
            GRANT: begin
               if (!empty[cur_reg]) begin
                  pop_fire  = 1'b1;
                  bcnt_next = bcnt_inc;
                  if (bcnt_inc == BCW'(BURST)) begin
                     state_next = IDLE;
                     ptr_next   = IDXW'(wrap_inc(32'(cur_reg), NUM_REQS));
                  end
               end else begin
                  // Owner ran dry early: give up the grant, costing one bubble.
                  state_next = IDLE;
                  ptr_next   = IDXW'(wrap_inc(32'(cur_reg), NUM_REQS));
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   generate
      for (gi = 0; gi < NUM_REQS; gi++) begin : g_pop
         assign pop[gi] = pop_fire & (sel == IDXW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         cur_reg   <= '0;
         bcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         cur_reg   <= cur_next;
         bcnt_reg  <= bcnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_src  <= '0;
      end else if (pop_fire) begin
         out_vld  <= 1'b1;
         out_data <= head[sel];
         out_src  <= sel;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

`ifdef SCHED_STATS_EN
   generate
      for (gi = 0; gi < NUM_REQS; gi++) begin : g_stats
         logic [STATW-1:0] cnt_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg <= '0;
            end else if (pop[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
         assign flat_pop_cnt[gi*STATW +: STATW] = cnt_reg;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// Randomized bench for fifo_pop_scheduler: a queue-based FIFO bank plus a
// transaction-level scheduling model predict pop and the output port each cycle.
module tb_fifo_pop_scheduler;

   localparam int NUM_REQS = 4;
   localparam int WIDTH    = 8;
   localparam int BURST    = 4;
   localparam int IDXW     = 2;
   localparam int STATW    = 16;
   localparam int DEPTH    = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQS-1:0]       empty;
   logic [NUM_REQS*WIDTH-1:0] flat_head;
   logic                      blk;
   logic [NUM_REQS-1:0]       pop;
   logic                      out_vld;
   logic                      out_rdy;
   logic [WIDTH-1:0]          out_data;
   logic [IDXW-1:0]           out_src;
`ifdef SCHED_STATS_EN
   logic [NUM_REQS*STATW-1:0] flat_pop_cnt;
`endif

   always #5 clk = ~clk;

   fifo_pop_scheduler #(
      .NUM_REQS (NUM_REQS),
      .WIDTH    (WIDTH),
      .BURST    (BURST),
      .IDXW     (IDXW),
      .STATW    (STATW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .empty     (empty),
      .flat_head (flat_head),
      .blk       (blk),
      .pop       (pop),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .out_src   (out_src)
`ifdef SCHED_STATS_EN
      ,
      .flat_pop_cnt (flat_pop_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] fifo_q [NUM_REQS][$];

   // Model: owner < 0 means nobody holds the port.
   int               m_ptr;
   int               m_owner;
   int               m_used;
   bit               m_vld;
   logic [WIDTH-1:0] m_data;
   int               m_src;
   int               m_cnt [NUM_REQS];
   int               n_out = 0;
   int               n_src1 = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_owner = -1;
      m_used  = 0;
      m_vld   = 1'b0;
      m_data  = '0;
      m_src   = 0;
      for (int i = 0; i < NUM_REQS; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step(input bit rdy, input bit b, output int w);
      w = -1;
      if ((!m_vld || rdy) && !b) begin
         if (m_owner < 0) begin
            for (int k = 0; k < NUM_REQS; k++) begin
               int c;
               c = (m_ptr + k) % NUM_REQS;
               if (fifo_q[c].size() > 0) begin
                  w = c;
                  break;
               end
            end
            if (w >= 0) begin
               m_used = 1;
               if (BURST == 1) m_ptr = (w + 1) % NUM_REQS;
               else            m_owner = w;
            end
         end else if (fifo_q[m_owner].size() > 0) begin
            w = m_owner;
            m_used++;
            if (m_used == BURST) begin
               m_ptr   = (m_owner + 1) % NUM_REQS;
               m_owner = -1;
            end
         end else begin
            m_ptr   = (m_owner + 1) % NUM_REQS;
            m_owner = -1;
         end
      end
      if (w >= 0) begin
         m_data = fifo_q[w][0];
         m_src  = w;
         m_vld  = 1'b1;
         if (m_cnt[w] < (2**STATW) - 1) m_cnt[w]++;
      end else if (rdy) begin
         m_vld = 1'b0;
      end
   endtask

   task automatic check_stats();
`ifdef SCHED_STATS_EN
      for (int i = 0; i < NUM_REQS; i++)
         check_val("pop_cnt", flat_pop_cnt[i*STATW +: STATW], m_cnt[i]);
`endif
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic run_cycle(input int rdy_pct, input int blk_pct, input int push_pct);
      int w;
      logic [NUM_REQS-1:0] exp_pop;
      for (int i = 0; i < NUM_REQS; i++) begin
         empty[i] = (fifo_q[i].size() == 0);
         flat_head[i*WIDTH +: WIDTH] = empty[i] ? '0 : fifo_q[i][0];
      end
      out_rdy = ($urandom_range(99) < rdy_pct);
      blk     = ($urandom_range(99) < blk_pct);
      #4;
      check_val("out_vld", out_vld, m_vld);
      if (m_vld) begin
         check_val("out_data", out_data, m_data);
         check_val("out_src", out_src, m_src);
         if (out_rdy) begin
            n_out++;
            if (out_src == 1) n_src1++;
            $display("OUT #%0d src=%0d data=%02h", n_out, out_src, out_data);
         end
      end
      model_step(out_rdy, blk, w);
      exp_pop = '0;
      if (w >= 0) exp_pop[w] = 1'b1;
      check_val("pop", pop, exp_pop);
      if (w >= 0) void'(fifo_q[w].pop_front());
      for (int i = 0; i < NUM_REQS; i++)
         if (($urandom_range(99) < push_pct) && (fifo_q[i].size() < DEPTH))
            fifo_q[i].push_back(WIDTH'($urandom));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tries;
      int s1;
      bit drained;
      rst       = 1'b0;
      blk       = 1'b0;
      out_rdy   = 1'b1;
      empty     = '1;
      flat_head = '0;
      model_reset();
      #2;
      check_val("rst_pop", pop, '0);
      check_val("rst_out_vld", out_vld, 1'b0);
      check_val("rst_out_data", out_data, '0);
      check_val("rst_out_src", out_src, '0);
      check_stats();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Idle port with nothing queued.
      repeat (20) run_cycle(100, 0, 0);

      // Single requester: a full burst, re-grant, then the remainder.
      for (int j = 0; j < 6; j++) fifo_q[1].push_back(WIDTH'(8'h10 + j));
      s1 = n_src1;
      repeat (15) run_cycle(100, 0, 0);
      check_val("fifo1_outputs", 32'(n_src1 - s1), 32'd6);

      // All requesters loaded: full-rate rotation.
      for (int i = 0; i < NUM_REQS; i++)
         for (int j = 0; j < 8; j++) fifo_q[i].push_back(WIDTH'($urandom));
      repeat (40) run_cycle(100, 0, 0);

      // Random pushes, backpressure and blocking.
      repeat (600) run_cycle(70, 10, 30);

      // Reset while a grant is active and the output holds a packet.
      tries = 0;
      while (!(m_owner >= 0 && m_vld) && tries < 200) begin
         run_cycle(80, 5, 40);
         tries++;
      end
      check_val("reset_window_found", (m_owner >= 0 && m_vld), 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_val("midrst_pop", pop, '0);
      check_val("midrst_out_vld", out_vld, 1'b0);
      check_val("midrst_out_data", out_data, '0);
      check_val("midrst_out_src", out_src, '0);
      model_reset();
      check_stats();
      @(posedge clk);
      #1;
      rst = 1'b1;

      repeat (300) run_cycle(60, 10, 25);

      // Drain everything with an always-ready consumer.
      tries   = 0;
      drained = 1'b0;
      while (!drained && tries < 500) begin
         run_cycle(100, 0, 0);
         tries++;
         drained = !m_vld;
         for (int i = 0; i < NUM_REQS; i++)
            if (fifo_q[i].size() != 0) drained = 1'b0;
      end
      check_val("drained", drained, 1'b1);
      check_stats();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
